// File: rtl/fw_event_mailbox_wb.sv
// Wishbone event mailbox: firmware posts report/warning/error/compare events into a FIFO drained via valid/ready.
// Optional firmware-hang watchdog enabled by defining FW_WATCHDOG_EN.
module fw_event_mailbox_wb #(
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] wb_dat_o,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    output logic [2:0]  evt_type_o,
    output logic [31:0] evt_code_o,
    output logic        evt_pass_o,
    output logic        overflow_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [2:0]  typ;
        logic [31:0] code;
        logic        pass;
    } evt_t;

    logic             ack_q, err_q;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      code_q, code_d, exp_q, exp_d, meas_q, meas_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic             ovf_q, ovf_d;
    evt_t             mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    evt_t             head_q, head_d;
    logic             vld_q;

    logic [5:0] offs;
    logic       access, mapped, wr_acc, rd_acc;
    logic       ctl_push, wdog_fire, wdog_fired;
    logic       push_req, push_acc, pop, full;
    evt_t       push_rec, ctl_rec;
    logic       unused;

    assign offs   = wb_adr_i[7:2];
    assign access = wb_cyc_i & wb_stb_i & ~(ack_q | err_q);
    assign mapped = (offs <= 6'd6);
    assign wr_acc = access & mapped & wb_we_i;
    assign rd_acc = access & mapped & ~wb_we_i;
    assign unused = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

`ifdef FW_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_LIMIT + 1);
    logic [WW-1:0] wcnt_q;
    logic          wdog_q;

    // Fires on the cycle the idle count would reach the limit; the count then parks there.
    assign wdog_fire  = ~wr_acc & (wcnt_q == WW'(WDOG_LIMIT - 1));
    assign wdog_fired = wdog_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            if (wr_acc)                          wcnt_q <= '0;
            else if (wcnt_q != WW'(WDOG_LIMIT))  wcnt_q <= wcnt_q + WW'(1);
            if (wdog_fire)                                    wdog_q <= 1'b1;
            else if (wr_acc && offs == 6'd4 && wb_dat_i[17])  wdog_q <= 1'b0;
        end
    end
`else
    assign wdog_fire  = 1'b0;
    assign wdog_fired = 1'b0;
`endif

    always_comb begin
        code_d   = code_q;
        exp_d    = exp_q;
        meas_d   = meas_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        dat_d    = '0;
        ctl_push = 1'b0;
        ctl_rec  = '0;
        if (wr_acc) begin
            case (offs)
                6'd0: if (|wb_dat_i[3:0]) begin
                    ctl_push     = 1'b1;
                    ctl_rec.code = code_q;
                    if (wb_dat_i[3])      ctl_rec.typ = 3'd3;
                    else if (wb_dat_i[2]) begin
                        ctl_rec.typ  = 3'd4;
                        ctl_rec.pass = (exp_q == meas_q);
                        if (exp_q == meas_q) begin
                            if (pass_q != {CNT_W{1'b1}}) pass_d = pass_q + CNT_W'(1);
                        end else begin
                            if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + CNT_W'(1);
                        end
                    end
                    else if (wb_dat_i[1]) ctl_rec.typ = 3'd2;
                    else                  ctl_rec.typ = 3'd1;
                end
                6'd1:    code_d = bmerge(code_q, wb_dat_i, wb_sel_i);
                6'd2:    exp_d  = bmerge(exp_q, wb_dat_i, wb_sel_i);
                6'd3:    meas_d = bmerge(meas_q, wb_dat_i, wb_sel_i);
                6'd5:    pass_d = '0;
                6'd6:    fail_d = '0;
                default: ;
            endcase
        end
        if (rd_acc) begin
            case (offs)
                6'd1:    dat_d = code_q;
                6'd2:    dat_d = exp_q;
                6'd3:    dat_d = meas_q;
                6'd4:    dat_d = {14'd0, wdog_fired, ovf_q, 16'(cnt_q)};
                6'd5:    dat_d = 32'(pass_q);
                6'd6:    dat_d = 32'(fail_q);
                default: dat_d = '0;
            endcase
        end
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        pop      = vld_q & evt_ready_i;
        full     = (cnt_q == LW'(DEPTH));
        push_req = ctl_push | wdog_fire;
        push_rec = ctl_push ? ctl_rec : '{typ: 3'd5, code: code_q, pass: 1'b0};
        push_acc = push_req & (~full | pop);

        ovf_d = ovf_q;
        if (wr_acc && offs == 6'd4 && wb_dat_i[16]) ovf_d = 1'b0;
        if (push_req && full && !pop)               ovf_d = 1'b1;

        rd_d  = pop      ? rd_q + AW'(1) : rd_q;
        wr_d  = push_acc ? wr_q + AW'(1) : wr_q;
        cnt_d = cnt_q;
        if (push_acc && !pop)      cnt_d = cnt_q + LW'(1);
        else if (!push_acc && pop) cnt_d = cnt_q - LW'(1);

        if (cnt_d == '0)                    head_d = '0;
        else if (push_acc && wr_q == rd_d)  head_d = push_rec;
        else                                head_d = mem_q[rd_d];
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_acc) mem_q[wr_q] <= push_rec;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
            code_q <= '0;
            exp_q  <= '0;
            meas_q <= '0;
            pass_q <= '0;
            fail_q <= '0;
            ovf_q  <= 1'b0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            ack_q  <= access & mapped;
            err_q  <= access & ~mapped;
            dat_q  <= dat_d;
            code_q <= code_d;
            exp_q  <= exp_d;
            meas_q <= meas_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            ovf_q  <= ovf_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            vld_q  <= (cnt_d != '0);
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_dat_o    = dat_q;
    assign evt_valid_o = vld_q;
    assign evt_type_o  = head_q.typ;
    assign evt_code_o  = head_q.code;
    assign evt_pass_o  = head_q.pass;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_fw_event_mailbox_wb.sv
// Directed bench for fw_event_mailbox_wb (DEPTH=8, CNT_W=3 so counter saturation is reachable).
module tb_fw_event_mailbox_wb;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
    logic        evt_valid_o, evt_ready_i, evt_pass_o, overflow_o;
    logic [2:0]  evt_type_o;
    logic [31:0] evt_code_o;

    int nvec = 0;
    int nmis = 0;

    localparam logic [31:0] A_CTL = 32'h00, A_CODE = 32'h04, A_EXP = 32'h08, A_MEAS = 32'h0C,
                            A_STAT = 32'h10, A_PASS = 32'h14, A_FAIL = 32'h18, A_BAD = 32'h1C;

    fw_event_mailbox_wb #(.DEPTH(8), .CNT_W(3), .WDOG_LIMIT(50)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_type_o(evt_type_o),
        .evt_code_o(evt_code_o), .evt_pass_o(evt_pass_o), .overflow_o(overflow_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One Wishbone access; response sampled 1ns after the access edge.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic popi,
                        output logic [31:0] rdat, output logic ack, output logic err);
        @(negedge wb_clk_i);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = sel;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; evt_ready_i = popi;
        @(posedge wb_clk_i); #1;
        ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; evt_ready_i = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] r; logic a, e;
        xfer(adr, 1'b1, d, 4'hF, 1'b0, r, a, e);
        chk("wr_ack", 32'(a), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r; logic a, e;
        xfer(adr, 1'b0, 32'd0, 4'hF, 1'b0, r, a, e);
        chk({tag, "_ack"}, 32'(a), 32'd1);
        chk(tag, r, exp);
    endtask

    task automatic pop_chk(input string tag, input logic [2:0] typ, input logic [31:0] code,
                           input logic pass);
        chk({tag, "_vld"}, 32'(evt_valid_o), 32'd1);
        chk({tag, "_type"}, 32'(evt_type_o), 32'(typ));
        chk({tag, "_code"}, evt_code_o, code);
        chk({tag, "_pass"}, 32'(evt_pass_o), 32'(pass));
        @(negedge wb_clk_i); evt_ready_i = 1'b1;
        @(posedge wb_clk_i); #1; evt_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] r; logic a, e; logic [3:0] pat; logic [31:0] dlow;
        wb_rst_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; evt_ready_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_err", 32'(wb_err_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_vld", 32'(evt_valid_o), 32'd0);
        chk("rst_head", {evt_code_o[27:0], evt_type_o, evt_pass_o}, 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        rd("rst_stat", A_STAT, 32'd0);

        // T1: report event, ack one cycle after access, head valid next cycle
        wr(A_CODE, 32'hDEAD0001);
        chk("t1_pre_vld", 32'(evt_valid_o), 32'd0);
        wr(A_CTL, 32'h1);
        rd("t1_level", A_STAT, 32'd1);
        pop_chk("t1", 3'd1, 32'hDEAD0001, 1'b0);
        chk("t1_empty", 32'(evt_valid_o), 32'd0);
        wr(A_CTL, 32'h3);
        pop_chk("warn", 3'd2, 32'hDEAD0001, 1'b0);
        rd("ctl_rd0", A_CTL, 32'd0);
        wr(A_CTL, 32'h0);
        rd("ctl0_nopush", A_STAT, 32'd0);

        // Byte-masked write: bytes 0 and 2 only
        xfer(A_CODE, 1'b1, 32'h11223344, 4'b0101, 1'b0, r, a, e);
        rd("bmask", A_CODE, 32'hDE220044);

        // Strobe held on a read: ack 1,0,1,0 and data zero while ack low
        @(negedge wb_clk_i);
        wb_adr_i = A_CODE; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        dlow = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk_i); #1;
            pat[i] = wb_ack_o;
            if (i == 1) dlow = wb_dat_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        chk("held_ack_pat", 32'(pat), 32'h5);
        chk("held_dat_low", dlow, 32'd0);
        @(posedge wb_clk_i); #1;

        // T2: compare pass then fail
        wr(A_EXP, 32'h55); wr(A_MEAS, 32'h55); wr(A_CTL, 32'h4);
        pop_chk("t2_pass", 3'd4, 32'hDE220044, 1'b1);
        wr(A_MEAS, 32'h56); wr(A_CTL, 32'h4);
        pop_chk("t2_fail", 3'd4, 32'hDE220044, 1'b0);
        rd("t2_pcnt", A_PASS, 32'd1);
        rd("t2_fcnt", A_FAIL, 32'd1);

        // Fail counter saturates at 7 (CNT_W=3); 8 entries fill FIFO exactly
        for (int i = 0; i < 8; i++) wr(A_CTL, 32'h4);
        chk("sat_noovf", 32'(overflow_o), 32'd0);
        rd("sat_fcnt", A_FAIL, 32'd7);
        rd("sat_level", A_STAT, 32'd8);
        wr(A_FAIL, 32'h0);
        rd("fcnt_clr", A_FAIL, 32'd0);
        rd("pcnt_keep", A_PASS, 32'd1);
        wr(A_PASS, 32'h1234);
        rd("pcnt_clr", A_PASS, 32'd0);
        for (int i = 0; i < 8; i++) pop_chk("sat_drain", 3'd4, 32'hDE220044, 1'b0);

        // T3: 9 pushes into 8 entries -> overflow, first 8 kept in order
        for (int i = 0; i < 9; i++) begin
            wr(A_CODE, 32'h100 + 32'(i));
            wr(A_CTL, 32'h1);
        end
        rd("t3_stat", A_STAT, 32'h0001_0008);
        chk("t3_ovf", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 8; i++) pop_chk("t3_order", 3'd1, 32'h100 + 32'(i), 1'b0);
        chk("t3_empty", 32'(evt_valid_o), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow_o), 32'd1);
        wr(A_STAT, 32'h0001_0000);
        chk("ovf_clr", 32'(overflow_o), 32'd0);

        // T4: full FIFO, push with simultaneous pop
        for (int i = 0; i < 8; i++) begin
            wr(A_CODE, 32'h200 + 32'(i));
            wr(A_CTL, 32'h1);
        end
        wr(A_CODE, 32'h208);
        xfer(A_CTL, 1'b1, 32'h1, 4'hF, 1'b1, r, a, e);
        chk("t4_ack", 32'(a), 32'd1);
        rd("t4_stat", A_STAT, 32'h0000_0008);
        chk("t4_ovf", 32'(overflow_o), 32'd0);
        for (int i = 1; i < 9; i++) pop_chk("t4_order", 3'd1, 32'h200 + 32'(i), 1'b0);

        // T5: all request bits -> single error event; unmapped offset -> err, no effect
        wr(A_CTL, 32'hF);
        rd("t5_level", A_STAT, 32'd1);
        pop_chk("t5", 3'd3, 32'h208, 1'b0);
        chk("t5_empty", 32'(evt_valid_o), 32'd0);
        xfer(A_BAD, 1'b0, 32'd0, 4'hF, 1'b0, r, a, e);
        chk("t5_rd_err", 32'(e), 32'd1);
        chk("t5_rd_ack", 32'(a), 32'd0);
        chk("t5_rd_dat", r, 32'd0);
        xfer(A_BAD, 1'b1, 32'hF, 4'hF, 1'b0, r, a, e);
        chk("t5_wr_err", 32'(e), 32'd1);
        rd("t5_nopush", A_STAT, 32'd0);
        rd("t5_code", A_CODE, 32'h208);

`ifdef FW_WATCHDOG_EN
        // T6: 50 idle cycles -> one watchdog event, sticky cleared by write
        wr(A_CODE, 32'hABCD);
        repeat (60) @(posedge wb_clk_i);
        #1;
        rd("t6_stat", A_STAT, 32'h0002_0001);
        pop_chk("t6", 3'd5, 32'hABCD, 1'b0);
        repeat (60) @(posedge wb_clk_i);
        #1;
        chk("t6_once", 32'(evt_valid_o), 32'd0);
        wr(A_STAT, 32'h0002_0000);
        rd("t6_clr", A_STAT, 32'd0);
`else
        repeat (60) @(posedge wb_clk_i);
        #1;
        rd("nowdog_stat", A_STAT, 32'd0);
        chk("nowdog_vld", 32'(evt_valid_o), 32'd0);
`endif

        // Reset during a CONTROL write discards it
        wr(A_CTL, 32'h1);
        @(negedge wb_clk_i);
        wb_adr_i = A_CTL; wb_we_i = 1'b1; wb_dat_i = 32'h1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("mrst_ack", 32'(wb_ack_o), 32'd0);
        chk("mrst_vld", 32'(evt_valid_o), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        rd("mrst_stat", A_STAT, 32'd0);
        rd("mrst_code", A_CODE, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
